// File: rtl/data_sram_responder.sv
// Data SRAM responder: byte-masked writes, full-word registered reads,
// optional wait states with a combinational stall back to the requester.
module data_sram_responder #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        data_sram_rvalid,
   output logic        data_sram_stall
);

   localparam int         DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

   logic [3:0]            cnt_reg, cnt_next;
   logic [31:0]           rdata_reg, rdata_next;
   logic                  rvalid_reg, rvalid_next;
   logic [ADDR_WIDTH-1:0] word_index;
   logic [31:0]           mem_word;
   logic                  access;
   logic                  unused_addr_bits;

   // Byte offset and high address bits are dropped, so addresses alias.
   assign word_index       = data_sram_addr[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

   assign data_sram_stall = data_sram_en && (cnt_reg != WAIT_LAST);
   // A request arriving while reset is held must never reach the array.
   assign access          = resetn && data_sram_en && !data_sram_stall;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];

         always_ff @(posedge clk) begin
            if (access && data_sram_wen[gi]) begin
               lane_mem[word_index] <= data_sram_wdata[8*gi +: 8];
            end
         end

         assign mem_word[8*gi +: 8] = lane_mem[word_index];
      end
   endgenerate

   always_comb begin
      cnt_next    = cnt_reg;
      rdata_next  = rdata_reg;
      rvalid_next = 1'b0;
      if (!data_sram_en) begin
         cnt_next = 4'd0;
      end else if (data_sram_stall) begin
         cnt_next = cnt_reg + 4'd1;
      end else begin
         cnt_next = 4'd0;
         if (data_sram_wen == 4'b0000) begin
            rdata_next  = mem_word;
            rvalid_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_reg    <= 4'd0;
         rdata_reg  <= 32'd0;
         rvalid_reg <= 1'b0;
      end else begin
         cnt_reg    <= cnt_next;
         rdata_reg  <= rdata_next;
         rvalid_reg <= rvalid_next;
      end
   end

   assign data_sram_rdata  = rdata_reg;
   assign data_sram_rvalid = rvalid_reg;

endmodule
